// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls and mispredict flushes for IF/ID and ID/EX,
// sequenced by a small FSM, plus saturating stall-cycle and mispredict counters.
module hazard_control_unit #(
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES    = 1,
   parameter int unsigned CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [4:0]           id_rs1_addr_i,
   input  logic [4:0]           id_rs2_addr_i,
   input  logic                 id_rs1_used_i,
   input  logic                 id_rs2_used_i,
   input  logic [4:0]           ex_reg_wr_addr_i,
   input  logic                 ex_reg_wr_sig_i,
   input  logic                 ex_is_load_i,
   input  logic                 ex_br_sig_i,
   input  logic                 ex_br_taken_i,
   input  logic                 ex_br_pred_i,
   input  logic                 cnt_clr_i,
   output logic                 pc_stall_o,
   output logic                 if_id_stall_o,
   output logic                 if_id_flush_o,
   output logic                 id_ex_flush_o,
   output logic [1:0]           state_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);

   localparam int unsigned MAX_CYC = (LOAD_USE_CYCLES > FLUSH_CYCLES) ? LOAD_USE_CYCLES
                                                                      : FLUSH_CYCLES;
   localparam int unsigned DW = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LU_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] down_q, down_d;
   logic          mispredict, load_use;
   logic          stall_c, flush_c;

   assign mispredict = ex_br_sig_i & (ex_br_taken_i != ex_br_pred_i);
   assign load_use   = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 5'd0) &
                       ((id_rs1_used_i & (id_rs1_addr_i == ex_reg_wr_addr_i)) |
                        (id_rs2_used_i & (id_rs2_addr_i == ex_reg_wr_addr_i)));

   // State and bubble/flush down-counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         down_q  <= '0;
      end else begin
         state_q <= state_d;
         down_q  <= down_d;
      end
   end

   // Next state; stall_c and flush_c are mutually exclusive by construction
   always_comb begin
      state_d = state_q;
      down_d  = down_q;
      stall_c = 1'b0;
      flush_c = 1'b0;
      case (state_q)
         RUN, LU_WAIT: begin
            if (mispredict) begin
               flush_c = 1'b1;
               down_d  = DW'(FLUSH_CYCLES - 1);
               state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (state_q == LU_WAIT) begin
               stall_c = 1'b1;
               if (down_q == DW'(1)) state_d = RUN;
               else                  down_d  = down_q - DW'(1);
            end else if (load_use) begin
               stall_c = 1'b1;
               down_d  = DW'(LOAD_USE_CYCLES - 1);
               state_d = (LOAD_USE_CYCLES > 1) ? LU_WAIT : RUN;
            end
         end
         FLUSH: begin
            flush_c = 1'b1;
            if (mispredict)              down_d  = DW'(FLUSH_CYCLES - 1);
            else if (down_q == DW'(1))   state_d = RUN;
            else                         down_d  = down_q - DW'(1);
         end
         default: state_d = RUN;
      endcase
   end

   // Control outputs are held low for the whole reset assertion
   assign pc_stall_o    = stall_c & reset_n;
   assign if_id_stall_o = stall_c & reset_n;
   assign if_id_flush_o = flush_c & reset_n;
   assign id_ex_flush_o = (stall_c | flush_c) & reset_n;
   assign state_o       = 2'(state_q);

   // Saturating performance counters; clear wins over increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (pc_stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
         if (mispredict && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: dut_a (LU=2, FLUSH=3, CNT=4) and
// dut_b (LU=3, FLUSH=1, CNT=8) driven by directed vectors with hand-computed expectations.
module tb_hazard_control_unit;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] wa;
      logic       wr;
      logic       ld;
      logic       br;
      logic       tk;
      logic       pr;
      logic       clr;
   } vec_t;

   // ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
   typedef struct packed {
      logic        sel;
      logic [3:0]  ctrl;
      logic [1:0]  st;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   vec_t va = '0;
   vec_t vb = '0;

   logic       a_pc, a_ifs, a_iff, a_idf;
   logic [1:0] a_st;
   logic [3:0] a_sc, a_fc;
   logic       b_pc, b_ifs, b_iff, b_idf;
   logic [1:0] b_st;
   logic [7:0] b_sc, b_fc;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_control_unit #(.LOAD_USE_CYCLES(2), .FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .id_rs1_addr_i(va.rs1), .id_rs2_addr_i(va.rs2),
      .id_rs1_used_i(va.u1), .id_rs2_used_i(va.u2),
      .ex_reg_wr_addr_i(va.wa), .ex_reg_wr_sig_i(va.wr), .ex_is_load_i(va.ld),
      .ex_br_sig_i(va.br), .ex_br_taken_i(va.tk), .ex_br_pred_i(va.pr),
      .cnt_clr_i(va.clr),
      .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff), .id_ex_flush_o(a_idf),
      .state_o(a_st), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
   );

   hazard_control_unit #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(1), .CNT_WIDTH(8)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .id_rs1_addr_i(vb.rs1), .id_rs2_addr_i(vb.rs2),
      .id_rs1_used_i(vb.u1), .id_rs2_used_i(vb.u2),
      .ex_reg_wr_addr_i(vb.wa), .ex_reg_wr_sig_i(vb.wr), .ex_is_load_i(vb.ld),
      .ex_br_sig_i(vb.br), .ex_br_taken_i(vb.tk), .ex_br_pred_i(vb.pr),
      .cnt_clr_i(vb.clr),
      .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff), .id_ex_flush_o(b_idf),
      .state_o(b_st), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
   );

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] wa,
                               input logic wr, input logic ld, input logic br,
                               input logic tk, input logic pr, input logic clr);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.wa = wa;
      v.wr = wr; v.ld = ld; v.br = br; v.tk = tk; v.pr = pr; v.clr = clr;
      return v;
   endfunction

   // Drive one cycle of stimulus just after the rising edge and queue its expectation
   task automatic step(input logic sel, input logic rst_v, input vec_t v,
                       input logic [3:0] c, input logic [1:0] st,
                       input int unsigned sc, input int unsigned fc);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = rst_v;
      if (sel) begin vb = v; va = '0; end
      else     begin va = v; vb = '0; end
      e.sel = sel; e.ctrl = c; e.st = st; e.sc = 32'(sc); e.fc = 32'(fc);
      q.push_back(e);
   endtask

   // Monitor: compare every queued expectation at the falling edge
   always @(negedge clk) begin
      exp_t        e;
      logic [3:0]  ac;
      logic [1:0]  ast;
      logic [31:0] asc, afc;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.sel) begin
            ac = {b_pc, b_ifs, b_iff, b_idf}; ast = b_st; asc = 32'(b_sc); afc = 32'(b_fc);
         end else begin
            ac = {a_pc, a_ifs, a_iff, a_idf}; ast = a_st; asc = 32'(a_sc); afc = 32'(a_fc);
         end
         checks += 3;
         if (ac !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl dut%0d t=%0t: got %b expected %b", e.sel, $time, ac, e.ctrl);
         end
         if (ast !== e.st) begin
            errors++;
            $display("FAIL state dut%0d t=%0t: got %0d expected %0d", e.sel, $time, ast, e.st);
         end
         if ((asc !== e.sc) || (afc !== e.fc)) begin
            errors++;
            $display("FAIL counters dut%0d t=%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     e.sel, $time, asc, afc, e.sc, e.fc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t idle, lu5, ldx0, nouse, nowr, mp_lu, mp, clr, okbr, lu5_clr, lu9, lu9_mp;
      idle    = '0;
      lu5     = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 0);
      ldx0    = mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 0);
      nouse   = mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 1, 0, 0, 0, 0);
      nowr    = mk(5'd7, 5'd2, 1, 1, 5'd7, 0, 1, 0, 0, 0, 0);
      mp_lu   = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0, 0);
      mp      = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0);
      clr     = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1);
      okbr    = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0);
      lu5_clr = mk(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 1);
      lu9     = mk(5'd9, 5'd1, 1, 1, 5'd9, 1, 1, 0, 0, 0, 0);
      lu9_mp  = mk(5'd9, 5'd1, 1, 1, 5'd9, 1, 1, 1, 1, 0, 0);

      // dut_a: reset holds outputs low despite active hazards
      step(0, 0, mp_lu, 4'b0000, 2'd0, 0, 0);
      step(0, 1, idle,  4'b0000, 2'd0, 0, 0);
      // load x5 / rs2 reads x5: two stall cycles
      step(0, 1, lu5,   4'b1101, 2'd0, 0, 0);
      step(0, 1, lu5,   4'b1101, 2'd1, 1, 0);
      step(0, 1, idle,  4'b0000, 2'd0, 2, 0);
      // no-hazard cases: x0, unused rs1, non-writing load
      step(0, 1, ldx0,  4'b0000, 2'd0, 2, 0);
      step(0, 1, nouse, 4'b0000, 2'd0, 2, 0);
      step(0, 1, nowr,  4'b0000, 2'd0, 2, 0);
      // mispredict beats load-use; three flush cycles
      step(0, 1, mp_lu, 4'b0011, 2'd0, 2, 0);
      step(0, 1, idle,  4'b0011, 2'd2, 2, 1);
      step(0, 1, idle,  4'b0011, 2'd2, 2, 1);
      step(0, 1, clr,   4'b0000, 2'd0, 2, 1);
      // second mispredict in flush cycle 2 extends to four cycles
      step(0, 1, mp,    4'b0011, 2'd0, 0, 0);
      step(0, 1, mp,    4'b0011, 2'd2, 0, 1);
      step(0, 1, idle,  4'b0011, 2'd2, 0, 2);
      step(0, 1, idle,  4'b0011, 2'd2, 0, 2);
      step(0, 1, idle,  4'b0000, 2'd0, 0, 2);
      step(0, 1, okbr,  4'b0000, 2'd0, 0, 2);
      // 20 continuous stall cycles saturate the 4-bit stall counter
      for (int i = 0; i < 20; i++)
         step(0, 1, lu5, 4'b1101, 2'(i % 2), (i > 15) ? 15 : i, 2);
      step(0, 1, lu5_clr, 4'b1101, 2'd0, 15, 2);
      step(0, 1, idle,    4'b1101, 2'd1, 0, 0);
      step(0, 1, idle,    4'b0000, 2'd0, 1, 0);

      // dut_b: reset in the second LU_WAIT cycle
      step(1, 1, lu9,   4'b1101, 2'd0, 0, 0);
      step(1, 1, lu9,   4'b1101, 2'd1, 1, 0);
      step(1, 0, lu9,   4'b0000, 2'd0, 0, 0);
      step(1, 1, idle,  4'b0000, 2'd0, 0, 0);
      // three-cycle load-use
      step(1, 1, lu9,   4'b1101, 2'd0, 0, 0);
      step(1, 1, lu9,   4'b1101, 2'd1, 1, 0);
      step(1, 1, lu9,   4'b1101, 2'd1, 2, 0);
      step(1, 1, idle,  4'b0000, 2'd0, 3, 0);
      // mispredict aborts LU_WAIT and returns to RUN with single-cycle flush
      step(1, 1, lu9,    4'b1101, 2'd0, 3, 0);
      step(1, 1, lu9_mp, 4'b0011, 2'd1, 4, 0);
      step(1, 1, idle,   4'b0000, 2'd0, 4, 1);
      step(1, 1, mp,     4'b0011, 2'd0, 4, 1);
      step(1, 1, idle,   4'b0000, 2'd0, 4, 2);

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
